mac_fifo: RTL
=============

# mac_fifo

Parametrised multiply-add engine with an input FIFO and a valid/ready output handshake; the successor to the fixed 8-bit, 4-slot multiply-add register. Operand triples (A, B, C) are queued in a DEPTH-entry ring buffer and drained through one registered compute stage producing either A*B+C per triple or the sum of A*B+C over a frame of DEPTH triples. It sits between an operand producer and a result consumer, and either side may stall.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- DEPTH, 4, FIFO entries and frame length in mode 1 (power of two, ≥2)
- OUT_W is derived, not a parameter: 2*WIDTH + $clog2(DEPTH) (18 at defaults)

- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- mode  in  1  0 = per-triple A*B+C; 1 = frame sum of DEPTH triples
- in_valid  in  1  producer offers A, B, C
- in_ready  out  1  FIFO can accept (count < DEPTH)
- A, B, C  in  WIDTH each  unsigned operands
- out_valid  out  1  out holds a result
- out_ready  in  1  consumer accepts out
- out  out  OUT_W  unsigned result, zero-extended in mode 0
- level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: in_valid & in_ready stores {A,B,C} at wr_ptr; wr_ptr wraps DEPTH-1→0. in_ready = (level < DEPTH), combinational from level only; a pop in the same cycle never raises it early.
- Pop: head entry consumed when level>0 and the compute stage can take it (rules below); rd_ptr wraps like wr_ptr. Push and pop in one cycle: level unchanged.
- Per-entry term p = A*B + C, computed in 2*WIDTH bits unsigned. Max (2^W-1)^2 + 2^W-1 < 2^2W, so no overflow. The frame sum of DEPTH terms fits OUT_W exactly, so no saturation logic.
- Mode 0: pop allowed when !out_valid | out_ready. Each pop loads out = p and sets out_valid.
- Mode 1: frame counter fcnt (0..DEPTH-1) and accumulator acc (OUT_W bits).
  - Pops with fcnt < DEPTH-1: acc += p, fcnt++. These do not wait on the output register.
  - Pop with fcnt == DEPTH-1 requires !out_valid | out_ready. It loads out = acc + p, sets out_valid, clears acc and fcnt.
- mode is latched into an internal register only when fcnt == 0. A change mid-frame takes effect after the frame completes.
- Output: out_valid & out_ready clears out_valid unless a new result loads in the same cycle. out and out_valid stay stable while out_valid & !out_ready.
- Reset (reset_n low, any time, including mid-frame): level=0, pointers=0, fcnt=0, acc=0, latched mode=0, out_valid=0, out=0; in_ready=1 once reset is released. FIFO contents are not cleared and are never visible.

## Timing
- Minimum latency, mode 0, empty FIFO, out_ready high: triple pushed at edge k, popped at edge k+1, out_valid high after edge k+1. One result per cycle sustained.
- Mode 1: out_valid rises one edge after the push of the frame's last triple, given an uninterrupted stream.
- Result-path throughput is one pop per cycle. No bubbles are inserted when out_ready stays high.
- Storage capacity is DEPTH queued triples plus one result in out, plus one partial frame in acc for mode 1.

## Test plan
- Reset/idle: reset_n low → out_valid=0, out=0, level=0; after release, in_ready=1.
- Mode 0 basic: push (3,4,5) with out_ready=1 → out=17 with out_valid one edge after the push. Then (255,255,255) → out=65280.
- Mode 1 frame: push (1,2,3), (2,3,4), (3,4,5), (4,5,6) → a single out=58. Four pushes of (255,255,255) → out=261120, no wrap.
- Backpressure, mode 0: out_ready=0, offer 6 triples → first is held in out, 4 fill the FIFO, level=4, in_ready=0, sixth stalls. Raise out_ready → all 6 emerge in push order, one per cycle.
- Mode switch mid-frame: mode=1, push 2 triples, set mode=0, push 2 more → one frame sum emitted. Subsequent triples are per-entry results.
- Reset mid-frame: mode 1, push 3 triples, pulse reset_n, then push (1,1,1) ×4 in mode 1 → out=8. No residue from the earlier triples.

Source files
------------

// File: rtl/mac_fifo.sv
// mac_fifo: operand-triple FIFO feeding one registered multiply-add stage.
// Mode 0 emits A*B+C per triple; mode 1 emits the sum of A*B+C over a frame
// of DEPTH triples. The input side uses a valid/ready handshake, and so does
// the output side; either side may stall.
module mac_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                mode,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    A,
  input  logic [WIDTH-1:0]                    B,
  input  logic [WIDTH-1:0]                    C,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*WIDTH+$clog2(DEPTH)-1:0]    out,
  output logic [$clog2(DEPTH):0]              level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 2 * WIDTH;
  localparam int OUT_W = PW + AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  // Operand storage; never reset, only entries between rd and wr are live.
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] mem_c_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    fcnt_q, fcnt_d;
  logic [AW:0]      level_q, level_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             mode_q, mode_d;

  logic             push;
  logic             pop;
  logic             mode_eff;
  logic             out_free;
  logic             frame_last;
  logic [PW-1:0]    term;
  logic [OUT_W-1:0] term_x;

  // A*B+C never exceeds 2*WIDTH bits, so the term needs no saturation.
  function automatic logic [PW-1:0] mac_term(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;
    logic [PW-1:0] c_x;
    a_x = {{WIDTH{1'b0}}, a};
    b_x = {{WIDTH{1'b0}}, b};
    c_x = {{WIDTH{1'b0}}, c};
    return (a_x * b_x) + c_x;
  endfunction

  // Handshake decode and the compute-stage term for the head entry.
  always_comb begin
    in_ready   = (level_q < FULL);
    out_free   = !out_valid_q || out_ready;
    // A frame boundary takes the live mode input; mid-frame keeps the latched one.
    mode_eff   = (fcnt_q == '0) ? mode : mode_q;
    frame_last = (fcnt_q == LAST);
    push       = in_valid && in_ready;
    // Non-final frame pops only touch acc, so they bypass the output stall.
    pop        = (level_q != '0) && ((mode_eff && !frame_last) || out_free);
    term       = mac_term(mem_a_q[rd_ptr_q], mem_b_q[rd_ptr_q], mem_c_q[rd_ptr_q]);
    term_x     = {{AW{1'b0}}, term};
  end

  // Next-state for pointers, occupancy, frame accumulation and result register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    fcnt_d      = fcnt_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    mode_d      = (fcnt_q == '0) ? mode : mode_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (pop) begin
      if (!mode_eff) begin
        out_d       = term_x;
        out_valid_d = 1'b1;
      end else if (!frame_last) begin
        acc_d  = acc_q + term_x;
        fcnt_d = fcnt_q + AW'(1);
      end else begin
        out_d       = acc_q + term_x;
        out_valid_d = 1'b1;
        acc_d       = '0;
        fcnt_d      = '0;
      end
    end
  end

  // Control and result state, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fcnt_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      fcnt_q      <= fcnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      mode_q      <= mode_d;
    end
  end

  // Operand write port.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= A;
      mem_b_q[wr_ptr_q] <= B;
      mem_c_q[wr_ptr_q] <= C;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;

endmodule
